tsmap_sram_arbiter: RTL
=======================

TSMAP_SRAM_ARBITER -- requirements
Module: tsmap_sram_arbiter

Interface
REQ-001 Parameter TSMapBase, 32'h200f_e000: byte base of the tag/revocation map.
REQ-002 Parameter DRamBase, 32'h200f_0000: byte base of the backing data SRAM.
REQ-003 Parameter TSMapWords, 2048: map size in 32-bit words; power of two, 256..16384.
REQ-004 Parameter NumAux, 1: auxiliary channels, 1..4.
REQ-005 Parameter StarveLimit, 15: starvation threshold in cycles, 1..255.
REQ-006 clk_i  in  1  single clock.
REQ-007 rstn_i  in  1  reset; asynchronous, active-low.
REQ-008 core_cs_i  in  1  core map read strobe; no stall possible.
REQ-009 core_addr_i  in  16  core word index.
REQ-010 core_rdata_o  out  32  core read data, one cycle after core_cs_i.
REQ-011 aux_req_i / aux_we_i  in  NumAux each  per-channel request and write flag.
REQ-012 aux_addr_i  in  NumAux*16  per-channel word index.
REQ-013 aux_wdata_i / aux_wmask_i  in  NumAux*32 each  write data and bit mask.
REQ-014 aux_gnt_o / aux_rvalid_o / aux_err_o  out  NumAux each  grant, response valid, response error.
REQ-015 aux_rdata_o  out  32  shared aux read data.
REQ-016 aux_starve_o  out  NumAux  starvation flags.
REQ-017 sram_cs_o / sram_we_o  out  1 each  SRAM strobe and write enable.
REQ-018 sram_addr_o  out  16  SRAM word address.
REQ-019 sram_wdata_o / sram_wmask_o  out  32 each  SRAM write data and bit mask.
REQ-020 sram_rdata_i  in  32  SRAM read data, one cycle after sram_cs_o.

Function
REQ-021 Address translation shall be: SRAM address = ((TSMapBase-DRamBase)>>2) + index[log2(TSMapWords)-1:0], 16-bit, wrap-around discarded.
REQ-022 Priority: when core_cs_i=1, the SRAM shall be issued the core read in that cycle, and no aux gnt shall be asserted.
REQ-023 Core index bits above log2(TSMapWords) shall be ignored; the core never errors.
REQ-024 When core_cs_i=0, at most one aux channel shall be granted per cycle, selected round-robin starting at pointer rr_q.
REQ-025 After a grant to channel k, rr_q shall become (k+1) mod NumAux; rr_q shall not change when there is no aux grant.
REQ-026 aux_gnt_o shall be combinational, in the same cycle as the accepted req; the requester shall hold req, we, addr, wdata and wmask stable until gnt.
REQ-027 Out-of-range aux index (>= TSMapWords): the request shall be granted, sram_cs_o shall stay 0, and the response shall carry err=1 with rdata 0.
REQ-028 Every granted aux request (read or write) shall get exactly one response, with aux_rvalid_o=1 on its channel, exactly one cycle after gnt.
REQ-029 aux_rdata_o shall be sram_rdata_i for in-range reads and 0 for writes, errors and idle cycles.
REQ-030 core_rdata_o shall be sram_rdata_i in the cycle after a core issue, and 0 otherwise.
REQ-031 Idle cycles shall drive sram_cs_o=0, sram_we_o=0, and 0 on addr, wdata and wmask.
REQ-032 Aux write: sram_we_o=1; wdata and wmask shall be passed unmodified; the core is always read-only.
REQ-033 Per-channel wait counter:
  - +1 each cycle req=1 and gnt=0, saturating at StarveLimit;
  - cleared on gnt;
  - aux_starve_o=1 while counter==StarveLimit.
REQ-034 Simultaneous core_cs_i and multiple aux requests: the core shall be served; all aux counters shall increment; rr_q shall be unchanged.

Reset
REQ-035 While rstn_i=0:
  - all registered state shall be 0: rr_q, counters, response pipeline;
  - aux_rvalid_o, aux_err_o, aux_starve_o, aux_rdata_o and core_rdata_o shall be 0.
REQ-036 A response in flight when reset asserts shall be dropped and never presented after reset release.
REQ-037 The first cycle after reset release shall accept requests normally.

Verification
REQ-038 core_cs_i=1, core_addr_i=0x0005 -> sram_addr_o=0x3805, sram_cs_o=1; next cycle core_rdata_o=sram_rdata_i.
REQ-039 core_addr_i=0x0805 -> sram_addr_o=0x3805 (upper index bits ignored).
REQ-040 NumAux=2, both aux requests held, core idle -> grants alternate ch0, ch1, ch0; each aux_rvalid_o follows its gnt by one cycle.
REQ-041 core_cs_i=1 for 15 cycles while aux0 requests -> aux_starve_o[0]=1 at cycle 15; it clears the cycle after gnt.
REQ-042 aux write, addr 0x0010, wdata 0xFFFF_0000, wmask 0x0000_FFFF -> sram_we_o=1, sram_addr_o=0x3810, mask passed; rvalid=1, err=0, rdata 0.
REQ-043 aux read, addr 0x0800 -> gnt=1, sram_cs_o=0; next cycle rvalid=1, err=1, rdata 0. Assert rstn_i during a pending response -> no rvalid after release.

Source files
------------

// File: rtl/tsmap_sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : tsmap_sram_arbiter_if
//  Purpose  : Bundles the core map-read port, the auxiliary request channels
//             and the SRAM port of the tag/revocation map arbiter.
//  Ports    : core_*  - single-cycle core read strobe, index and read data
//             aux_*   - NumAux request channels (req/we/addr/wdata/wmask in;
//                       gnt/rvalid/err/starve per channel, shared rdata out)
//             sram_*  - single-port SRAM strobe, address, write data/mask,
//                       read data returned one cycle after the strobe
//  Modports : slave  - arbiter side
//             master - requesters plus the SRAM macro
//  Revision : 1.0 - initial release
// ============================================================================
interface tsmap_sram_arbiter_if #(
   parameter int NumAux = 1
);
   logic                   core_cs_i;
   logic [15:0]            core_addr_i;
   logic [31:0]            core_rdata_o;

   logic [NumAux-1:0]      aux_req_i;
   logic [NumAux-1:0]      aux_we_i;
   logic [NumAux*16-1:0]   aux_addr_i;
   logic [NumAux*32-1:0]   aux_wdata_i;
   logic [NumAux*32-1:0]   aux_wmask_i;
   logic [NumAux-1:0]      aux_gnt_o;
   logic [NumAux-1:0]      aux_rvalid_o;
   logic [NumAux-1:0]      aux_err_o;
   logic [31:0]            aux_rdata_o;
   logic [NumAux-1:0]      aux_starve_o;

   logic                   sram_cs_o;
   logic                   sram_we_o;
   logic [15:0]            sram_addr_o;
   logic [31:0]            sram_wdata_o;
   logic [31:0]            sram_wmask_o;
   logic [31:0]            sram_rdata_i;

   modport slave (
      input  core_cs_i, core_addr_i,
      output core_rdata_o,
      input  aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i, aux_wmask_i,
      output aux_gnt_o, aux_rvalid_o, aux_err_o, aux_rdata_o, aux_starve_o,
      output sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
      input  sram_rdata_i
   );

   modport master (
      output core_cs_i, core_addr_i,
      input  core_rdata_o,
      output aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i, aux_wmask_i,
      input  aux_gnt_o, aux_rvalid_o, aux_err_o, aux_rdata_o, aux_starve_o,
      input  sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wmask_o,
      output sram_rdata_i
   );
endinterface
`default_nettype wire

// File: rtl/tsmap_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tsmap_sram_arbiter
//  Purpose  : Shares one SRAM between a never-stalling core reader of the
//             tag/revocation map and NumAux round-robin auxiliary channels.
//             Map word indices are translated to SRAM word addresses; aux
//             indices outside the map are granted but answered with an error.
//  Ports    : clk_i  - single clock
//             rstn_i - asynchronous active-low reset
//             bus    - tsmap_sram_arbiter_if.slave (core, aux, SRAM signals)
//  Revision : 1.0 - initial release
// ============================================================================
module tsmap_sram_arbiter #(
   parameter logic [31:0] TSMapBase   = 32'h200f_e000,
   parameter logic [31:0] DRamBase    = 32'h200f_0000,
   parameter int          TSMapWords  = 2048,
   parameter int          NumAux      = 1,
   parameter int          StarveLimit = 15
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   tsmap_sram_arbiter_if.slave   bus
);

   localparam int          IdxW      = $clog2(TSMapWords);
   localparam int          RrW       = (NumAux > 1) ? $clog2(NumAux) : 1;
   localparam logic [31:0] MapOffsW  = (TSMapBase - DRamBase) >> 2;
   localparam logic [15:0] MapOffs   = MapOffsW[15:0];
   localparam logic [7:0]  StarveMax = 8'(StarveLimit);

   // Map index -> SRAM word address; index bits above the map size are
   // dropped and the 16-bit sum wraps.
   function automatic logic [15:0] map_index(input logic [15:0] idx);
      return MapOffs + 16'(idx[IdxW-1:0]);
   endfunction

   logic [RrW-1:0]    r_rr_q;
   logic [7:0]        r_wait [NumAux];
   logic              r_core_rsp;
   logic [NumAux-1:0] r_rsp_vld;
   logic [NumAux-1:0] r_rsp_err;
   logic              r_rsp_rd;

   logic              w_core;
   logic              w_aux_any;
   logic [RrW-1:0]    w_sel;
   logic [NumAux-1:0] w_gnt;
   logic [15:0]       w_aux_addr;
   logic              w_aux_we;
   logic [31:0]       w_aux_wdata;
   logic [31:0]       w_aux_wmask;
   logic              w_aux_inrange;
   logic [RrW-1:0]    w_rr_next;
   logic [NumAux-1:0] w_starve;

   logic              w_sram_cs;
   logic              w_sram_we;
   logic [15:0]       w_sram_addr;
   logic [31:0]       w_sram_wdata;
   logic [31:0]       w_sram_wmask;

   assign w_core = bus.core_cs_i;

   // Round-robin search: first requesting channel at or after r_rr_q.
   always_comb begin : p_rr_search
      int ch;
      ch        = 0;
      w_aux_any = 1'b0;
      w_sel     = '0;
      for (int i = 0; i < NumAux; i++) begin
         ch = (int'(r_rr_q) + i) % NumAux;
         if (!w_aux_any && bus.aux_req_i[ch]) begin
            w_aux_any = 1'b1;
            w_sel     = RrW'(ch);
         end
      end
   end

   // The core read pre-empts every aux channel in its cycle.
   always_comb begin
      w_gnt = '0;
      if (!w_core && w_aux_any) begin
         w_gnt[w_sel] = 1'b1;
      end
   end

   assign w_aux_addr    = bus.aux_addr_i[w_sel*16 +: 16];
   assign w_aux_we      = bus.aux_we_i[w_sel];
   assign w_aux_wdata   = bus.aux_wdata_i[w_sel*32 +: 32];
   assign w_aux_wmask   = bus.aux_wmask_i[w_sel*32 +: 32];
   assign w_aux_inrange = ((w_aux_addr >> IdxW) == 16'd0);
   assign w_rr_next     = (w_sel == RrW'(NumAux - 1)) ? '0 : w_sel + 1'b1;

   // SRAM command; out-of-range aux requests leave the SRAM idle.
   always_comb begin
      w_sram_cs    = 1'b0;
      w_sram_we    = 1'b0;
      w_sram_addr  = '0;
      w_sram_wdata = '0;
      w_sram_wmask = '0;
      if (w_core) begin
         w_sram_cs   = 1'b1;
         w_sram_addr = map_index(bus.core_addr_i);
      end else if (w_aux_any && w_aux_inrange) begin
         w_sram_cs   = 1'b1;
         w_sram_we   = w_aux_we;
         w_sram_addr = map_index(w_aux_addr);
         if (w_aux_we) begin
            w_sram_wdata = w_aux_wdata;
            w_sram_wmask = w_aux_wmask;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rr_q     <= '0;
         r_core_rsp <= 1'b0;
         r_rsp_vld  <= '0;
         r_rsp_err  <= '0;
         r_rsp_rd   <= 1'b0;
         for (int i = 0; i < NumAux; i++) begin
            r_wait[i] <= '0;
         end
      end else begin
         r_core_rsp <= w_core;
         r_rsp_vld  <= w_gnt;
         r_rsp_err  <= w_gnt & {NumAux{~w_aux_inrange}};
         // Only in-range aux reads forward SRAM data on the shared bus.
         r_rsp_rd   <= (|w_gnt) && w_aux_inrange && !w_aux_we;
         if (|w_gnt) begin
            r_rr_q <= w_rr_next;
         end
         for (int i = 0; i < NumAux; i++) begin
            if (w_gnt[i]) begin
               r_wait[i] <= '0;
            end else if (bus.aux_req_i[i] && (r_wait[i] != StarveMax)) begin
               r_wait[i] <= r_wait[i] + 8'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NumAux; g++) begin : g_starve
      assign w_starve[g] = (r_wait[g] == StarveMax);
   end

   assign bus.aux_gnt_o    = w_gnt;
   assign bus.aux_rvalid_o = r_rsp_vld;
   assign bus.aux_err_o    = r_rsp_err;
   assign bus.aux_rdata_o  = r_rsp_rd   ? bus.sram_rdata_i : 32'd0;
   assign bus.core_rdata_o = r_core_rsp ? bus.sram_rdata_i : 32'd0;
   assign bus.aux_starve_o = w_starve;

   assign bus.sram_cs_o    = w_sram_cs;
   assign bus.sram_we_o    = w_sram_we;
   assign bus.sram_addr_o  = w_sram_addr;
   assign bus.sram_wdata_o = w_sram_wdata;
   assign bus.sram_wmask_o = w_sram_wmask;

endmodule
`default_nettype wire
